// File: rtl/calc_arb_pkg.sv
// Shared defaults and FSM encoding for the calc engine arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package calc_arb_pkg;

    localparam int N_REQ_DEF   = 4;
    localparam int DATA_W_DEF  = 16;
    localparam int RES_W_DEF   = 32;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin pick: first set req bit strictly after ptr, wrapping around.
// Latency: combinational.
// Backpressure: none; output is don't-care when req is all zero.
module rr_priority_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] win_oh,
    output logic [IDX_W-1:0] win_idx
);

    logic found;
    int   cand;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = 0;
        // Offsets 1..N_REQ so the last winner gets lowest priority.
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(ptr) + k) % N_REQ;
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = IDX_W'(cand);
            end
        end
        if (found) begin
            win_oh[win_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/calc_arbiter.sv
// Shares one iterative calc engine among N_REQ requesters, round-robin, with a watchdog.
// Latency: gnt one cycle after req sampled in IDLE; resp_valid one cycle after eng_output_valid.
// Backpressure: requesters hold req until gnt; engine must answer within TIMEOUT WAIT cycles.
module calc_arbiter
    import calc_arb_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RES_W   = RES_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          gnt,
    output logic                      eng_input_valid,
    output logic [DATA_W-1:0]         eng_x,
    input  logic                      eng_output_valid,
    input  logic [RES_W-1:0]          eng_result,
    output logic [N_REQ-1:0]          resp_valid,
    output logic [RES_W-1:0]          resp_data,
    output logic                      resp_err,
    output logic                      busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, win_idx_q, pick_idx;
    logic [N_REQ-1:0]   win_oh_q, pick_oh;
    logic [WD_W-1:0]    wdog_q;
    logic               err_q;
    logic [RES_W-1:0]   res_q;
    logic [DATA_W-1:0]  x_q;
    logic               wd_expire;

    rr_priority_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req     (req),
        .ptr     (ptr_q),
        .win_oh  (pick_oh),
        .win_idx (pick_idx)
    );

    assign wd_expire = (wdog_q == WD_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (|req) state_d = ST_LAUNCH;
            ST_LAUNCH:  state_d = ST_WAIT;
            ST_WAIT:    if (eng_output_valid || wd_expire) state_d = ST_RESPOND;
            ST_RESPOND: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= IDX_W'(N_REQ - 1);
            win_idx_q <= '0;
            win_oh_q  <= '0;
            wdog_q    <= '0;
            err_q     <= 1'b0;
            res_q     <= '0;
            x_q       <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        win_idx_q <= pick_idx;
                        win_oh_q  <= pick_oh;
                        x_q       <= req_data[pick_idx*DATA_W +: DATA_W];
                    end
                end
                ST_LAUNCH: wdog_q <= '0;
                ST_WAIT: begin
                    // Completion takes precedence over a simultaneous timeout.
                    if (eng_output_valid) begin
                        res_q <= eng_result;
                        err_q <= 1'b0;
                    end else if (wd_expire) begin
                        res_q <= '0;
                        err_q <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                ST_RESPOND: ptr_q <= win_idx_q;
                default: ;
            endcase
        end
    end

    assign gnt             = (state_q == ST_LAUNCH)  ? win_oh_q : '0;
    assign eng_input_valid = (state_q == ST_LAUNCH);
    assign eng_x           = x_q;
    assign resp_valid      = (state_q == ST_RESPOND) ? win_oh_q : '0;
    assign resp_data       = res_q;
    assign resp_err        = (state_q == ST_RESPOND) && err_q;
    assign busy            = (state_q != ST_IDLE);

endmodule

// File: doc/calc_arbiter.md
CALC_ARBITER -- requirements
Module: calc_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters sharing the iterative calc engine.
REQ-002 Parameter DATA_W, default 16, SHALL set the width of operand X.
REQ-003 Parameter RES_W, default 32, SHALL set the width of the engine result.
REQ-004 Parameter TIMEOUT, default 64, SHALL set the maximum number of WAIT cycles before abort.
REQ-005 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-007 req  input  N_REQ  SHALL carry the per-requester level request, held until gnt.
REQ-008 req_data  input  N_REQ*DATA_W  SHALL carry the packed operands; slice i belongs to requester i.
REQ-009 gnt  output  N_REQ  SHALL be a one-hot, one-cycle acceptance pulse.
REQ-010 eng_input_valid  output  1  SHALL be the one-cycle engine start pulse.
REQ-011 eng_x  output  DATA_W  SHALL carry the latched operand to the engine.
REQ-012 eng_output_valid  input  1  SHALL be the engine completion strobe.
REQ-013 eng_result  input  RES_W  SHALL carry the engine result, valid with eng_output_valid.
REQ-014 resp_valid  output  N_REQ  SHALL be a one-hot, one-cycle response pulse to the served requester.
REQ-015 resp_data  output  RES_W  SHALL carry the result, valid with resp_valid.
REQ-016 resp_err  output  1  SHALL be high with resp_valid when the job timed out.
REQ-017 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, LAUNCH, WAIT, RESPOND.
REQ-019 IDLE: if any req bit is high, the winner SHALL be the first high bit at or after index (ptr+1) mod N_REQ, and the FSM SHALL go to LAUNCH; else stay.
REQ-020 On leaving IDLE, the winner index SHALL be registered and eng_x SHALL latch the winner's req_data slice.
REQ-021 LAUNCH, exactly one cycle: gnt[win]=1 and eng_input_valid=1; next state WAIT.
REQ-022 eng_x SHALL stay stable from LAUNCH through RESPOND.
REQ-023 WAIT: watchdog SHALL count from 0 each cycle; eng_output_valid=1 SHALL capture eng_result, clear the error flag, go to RESPOND.
REQ-024 WAIT: if the watchdog reaches TIMEOUT-1 without eng_output_valid, the FSM SHALL set the error flag, set resp_data to 0, go to RESPOND.
REQ-025 If eng_output_valid and timeout occur in the same cycle, completion SHALL win with resp_err=0.
REQ-026 RESPOND, exactly one cycle: resp_valid[win]=1, resp_data and resp_err driven; ptr SHALL update to win; next state IDLE.
REQ-027 Latency: req sampled in IDLE at cycle t SHALL give gnt at t+1; resp_valid SHALL come one cycle after the eng_output_valid cycle.
REQ-028 eng_output_valid outside WAIT SHALL be ignored.
REQ-029 A req dropped after the IDLE sample SHALL NOT cancel the job.
REQ-030 A req still high in IDLE after RESPOND SHALL count as a new request.
REQ-031 gnt, resp_valid and eng_input_valid SHALL never be asserted in the same cycle.

Reset
REQ-032 On reset: state=IDLE, ptr=N_REQ-1 (requester 0 first), watchdog=0, error flag=0.
REQ-033 On reset: gnt=0, resp_valid=0, eng_input_valid=0, resp_err=0, busy=0, eng_x=0, resp_data=0.
REQ-034 Reset mid-job SHALL abort without resp_valid; a later eng_output_valid SHALL be ignored.

Structure
REQ-035 Package calc_arb_pkg SHALL hold the state encoding and the default values of N_REQ, DATA_W, RES_W and TIMEOUT.
REQ-036 The round-robin selection SHALL be a separate combinational sub-module rr_priority_picker (inputs req and ptr; outputs one-hot winner and index).

Verification
REQ-037 Bench SHALL check: after reset, req=4'b0001 with X=5, engine returns 120 after 10 cycles -> gnt=0001 at t+1, one eng_input_valid, resp_valid=0001 with resp_data=120, resp_err=0.
REQ-038 Bench SHALL check: req=4'b1111 held for four jobs -> grant order 0,1,2,3, then 0 again.
REQ-039 Bench SHALL check: engine silent -> resp_valid after 64 WAIT cycles, resp_err=1, resp_data=0; next job proceeds normally.
REQ-040 Bench SHALL check: eng_output_valid on the 64th WAIT cycle -> resp_err=0 and result delivered.
REQ-041 Bench SHALL check: reset asserted in WAIT -> busy=0 next cycle, no resp_valid, stray eng_output_valid ignored.
REQ-042 Bench SHALL check: req[2] dropped the cycle after the IDLE sample -> job completes, resp_valid=0100.
